// File: rtl/reorder_blk_transpose_pkg.sv
// Shared definitions for the block reorder datapath: the mode encoding and the
// source-index function used by the reorder, inverse-reorder and load stages.
package reorder_blk_transpose_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS    = 2'd0,
    MODE_TRANSPOSE = 2'd1,
    MODE_ROT90     = 2'd2,
    MODE_RSVD      = 2'd3
  } reorder_mode_t;

  localparam int XFER_CNT_W = 16;

  // Source word index for output word k of a vector of N x N blocks.
  // Word k = b*N*N + r*N + c. The reserved mode maps like bypass.
  function automatic int perm_idx(input reorder_mode_t mode, input int k, input int n);
    int nn;
    int b;
    int r;
    int c;
    nn = n * n;
    b  = k / nn;
    r  = (k % nn) / n;
    c  = k % n;
    case (mode)
      MODE_TRANSPOSE: perm_idx = b * nn + c * n + r;
      MODE_ROT90:     perm_idx = b * nn + (n - 1 - c) * n + r;
      default:        perm_idx = k;
    endcase
  endfunction

endpackage

// File: rtl/reorder_blk_transpose_if.sv
// Bus bundle for the block reorder: input vector channel and output vector channel.
//
// Handshake: on each channel a word moves on a rising edge where valid && ready.
// The producer holds data/mode stable while valid is high and not yet taken;
// ready never depends combinationally on valid or on the other channel.
interface reorder_blk_transpose_if #(
  parameter int DATA_W  = 32,
  parameter int N       = 4,
  parameter int NUM_BLK = 4
) ();
  import reorder_blk_transpose_pkg::*;

  localparam int W = NUM_BLK * N * N;

  logic [DATA_W-1:0] in_data [W-1:0];
  reorder_mode_t     in_mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data [W-1:0];
  logic              out_valid;
  logic              out_ready;

  // Environment side: drives the input channel, consumes the output channel.
  modport master (
    output in_data, in_mode, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  // Block side.
  modport slave (
    input  in_data, in_mode, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/reorder_blk_transpose_perm.sv
// Combinational per-block permutation of a full vector; flags the reserved mode.
module reorder_blk_transpose_perm
  import reorder_blk_transpose_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int N       = 4,
  parameter int NUM_BLK = 4
) (
  input  logic [DATA_W-1:0] in_data  [NUM_BLK*N*N-1:0],
  input  reorder_mode_t     mode,
  output logic [DATA_W-1:0] out_data [NUM_BLK*N*N-1:0],
  output logic              mode_rsvd
);

  localparam int W     = NUM_BLK * N * N;
  localparam int IDX_W = $clog2(W);

  // Each output word selects its source word; k and N are constant per word,
  // so only a small mode-driven mux remains per output.
  always_comb begin
    for (int k = 0; k < W; k++) begin
      out_data[k] = in_data[IDX_W'(perm_idx(mode, k, N))];
    end
  end

  assign mode_rsvd = (mode == MODE_RSVD);

endmodule

// File: rtl/reorder_blk_transpose.sv
// Block reorder stage: permutes the incoming vector and queues it in a
// 2-entry FIFO with valid/ready flow control on both sides.
module reorder_blk_transpose
  import reorder_blk_transpose_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int N       = 4,
  parameter int NUM_BLK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  reorder_blk_transpose_if.slave bus,
  output logic [XFER_CNT_W-1:0] xfer_cnt,
  output logic                  mode_err
);

  localparam int W = NUM_BLK * N * N;

  logic [DATA_W-1:0]     perm_data [W-1:0];
  logic                  perm_rsvd;

  logic [DATA_W-1:0]     mem_q [0:1][W-1:0];
  logic [DATA_W-1:0]     mem_d [0:1][W-1:0];
  logic [1:0]            count_q, count_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [XFER_CNT_W-1:0] xfer_q, xfer_d;
  logic                  mode_err_q, mode_err_d;
  logic                  accept;
  logic                  deliver;

  reorder_blk_transpose_perm #(
    .DATA_W  (DATA_W),
    .N       (N),
    .NUM_BLK (NUM_BLK)
  ) u_perm (
    .in_data   (bus.in_data),
    .mode      (bus.in_mode),
    .out_data  (perm_data),
    .mode_rsvd (perm_rsvd)
  );

  // in_ready comes from the occupancy flop only, so a full buffer never
  // accepts even when the consumer drains in the same cycle.
  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign xfer_cnt      = xfer_q;
  assign mode_err      = mode_err_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign deliver = bus.out_valid && bus.out_ready;

  // Next-state: write on accept, advance read on deliver, track occupancy.
  always_comb begin
    mem_d      = mem_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    xfer_d     = xfer_q;
    mode_err_d = mode_err_q;
    if (accept) begin
      mem_d[wr_ptr_q] = perm_data;
      wr_ptr_d        = ~wr_ptr_q;
      if (perm_rsvd) begin
        mode_err_d = 1'b1;
      end
    end
    if (deliver) begin
      rd_ptr_d = ~rd_ptr_q;
      xfer_d   = xfer_q + XFER_CNT_W'(1);
    end
    case ({accept, deliver})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage: no reset, contents are only observed while out_valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control state with synchronous reset; reset drops buffered entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      xfer_q     <= '0;
      mode_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      xfer_q     <= xfer_d;
      mode_err_q <= mode_err_d;
    end
  end

endmodule

// File: tb/tb_reorder_blk_transpose.sv
// Directed bench for reorder_blk_transpose: default instance (32/4/4) and a
// small instance (8/2/1) for the parameter sweep and counter wrap.
module tb_reorder_blk_transpose;
  import reorder_blk_transpose_pkg::*;

  localparam int DW = 32;
  localparam int NN = 4;
  localparam int NB = 4;
  localparam int W  = NB * NN * NN;
  localparam int VW = W * DW;

  logic clk = 1'b0;
  logic rst;

  logic [15:0] xfer_cnt;
  logic        mode_err;
  logic [15:0] sm_xfer;
  logic        sm_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] stim [W-1:0];
  logic [VW-1:0] exp_q [$];

  reorder_blk_transpose_if #(.DATA_W(DW), .N(NN), .NUM_BLK(NB)) bus ();
  reorder_blk_transpose_if #(.DATA_W(8), .N(2), .NUM_BLK(1)) sm ();

  reorder_blk_transpose #(.DATA_W(DW), .N(NN), .NUM_BLK(NB)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .xfer_cnt (xfer_cnt),
    .mode_err (mode_err)
  );

  reorder_blk_transpose #(.DATA_W(8), .N(2), .NUM_BLK(1)) dut_sm (
    .clk      (clk),
    .rst      (rst),
    .bus      (sm),
    .xfer_cnt (sm_xfer),
    .mode_err (sm_err)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: walks block/row/column and reads the source word.
  function automatic logic [VW-1:0] model_vec(input logic [1:0] m);
    logic [VW-1:0] res;
    int k;
    int src;
    res = '0;
    for (int b = 0; b < NB; b++) begin
      for (int r = 0; r < NN; r++) begin
        for (int c = 0; c < NN; c++) begin
          k = b * NN * NN + r * NN + c;
          case (m)
            2'd1:    src = b * NN * NN + c * NN + r;
            2'd2:    src = b * NN * NN + (NN - 1 - c) * NN + r;
            default: src = k;
          endcase
          res[k*DW +: DW] = stim[src];
        end
      end
    end
    return res;
  endfunction

  function automatic logic [VW-1:0] flat_out();
    logic [VW-1:0] res;
    for (int k = 0; k < W; k++) res[k*DW +: DW] = bus.out_data[k];
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check_vec(input string tag, input logic [VW-1:0] exp);
    logic [VW-1:0] obs;
    int bad;
    obs = flat_out();
    bad = 0;
    checks++;
    assert (obs === exp) else begin
      errors++;
      for (int k = W - 1; k >= 0; k--) begin
        if (obs[k*DW +: DW] !== exp[k*DW +: DW]) bad = k;
      end
      $display("FAIL %s: word %0d got %h expected %h", tag, bad,
               obs[bad*DW +: DW], exp[bad*DW +: DW]);
      $error("check %s", tag);
    end
  endtask

  task automatic fill_idx();
    for (int k = 0; k < W; k++) stim[k] = DW'(k);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < W; k++) stim[k] = $urandom;
  endtask

  // Driver: present one vector, expect it accepted at the next edge.
  task automatic send(input logic [1:0] m, input string tag);
    bus.in_data  = stim;
    bus.in_mode  = reorder_mode_t'(m);
    bus.in_valid = 1'b1;
    check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    exp_q.push_back(model_vec(m));
  endtask

  // Driver: check the head vector and take it.
  task automatic pop_check(input string tag);
    check({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    check_vec({tag, "_vec"}, exp_q[0]);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_q.delete(0);
  endtask

  initial begin
    int cyc;
    logic [1:0] m;

    // Reset
    rst          = 1'b1;
    bus.in_data  = stim;
    bus.in_mode  = MODE_BYPASS;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) sm.in_data[k] = 8'd0;
    sm.in_mode   = MODE_BYPASS;
    sm.in_valid  = 1'b0;
    sm.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_xfer", 32'(xfer_cnt), 32'd0);
    check("rst_mode_err", 32'(mode_err), 32'd0);

    // Single TRANSPOSE, in[k] = k
    fill_idx();
    bus.in_data  = stim;
    bus.in_mode  = MODE_TRANSPOSE;
    bus.in_valid = 1'b1;
    check("tr_pre_valid", 32'(bus.out_valid), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    exp_q.push_back(model_vec(2'd1));
    check("tr_latency", 32'(bus.out_valid), 32'd1);
    check("tr_out1", bus.out_data[1], 32'd4);
    check("tr_out4", bus.out_data[4], 32'd1);
    check("tr_out17", bus.out_data[17], 32'd20);
    check("tr_out63", bus.out_data[63], 32'd63);
    check("tr_xfer_before", 32'(xfer_cnt), 32'd0);
    pop_check("tr");
    check("tr_xfer", 32'(xfer_cnt), 32'd1);
    check("tr_empty", 32'(bus.out_valid), 32'd0);

    // ROT90, in[k] = k
    send(2'd2, "rot");
    check("rot_out0", bus.out_data[0], 32'd12);
    check("rot_out3", bus.out_data[3], 32'd0);
    check("rot_out15", bus.out_data[15], 32'd3);
    check("rot_out48", bus.out_data[48], 32'd60);
    check("rot_out63", bus.out_data[63], 32'd51);
    pop_check("rot");

    // BYPASS, random data
    fill_rand();
    send(2'd0, "byp");
    pop_check("byp");
    check("byp_xfer", 32'(xfer_cnt), 32'd3);

    // Backpressure: two accepted, third held off while full
    fill_rand();
    send(2'd1, "bp_a");
    fill_rand();
    send(2'd2, "bp_b");
    fill_rand();
    bus.in_data  = stim;
    bus.in_mode  = MODE_BYPASS;
    bus.in_valid = 1'b1;
    check("bp_full_rdy", 32'(bus.in_ready), 32'd0);
    tick();
    check("bp_still_full", 32'(bus.in_ready), 32'd0);
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    check_vec("bp_stall_a", exp_q[0]);
    bus.out_ready = 1'b1;
    tick();
    exp_q.delete(0);
    check("bp_rdy_after_drain", 32'(bus.in_ready), 32'd1);
    check_vec("bp_b", exp_q[0]);
    tick();
    exp_q.delete(0);
    exp_q.push_back(model_vec(2'd0));
    check_vec("bp_c", exp_q[0]);
    bus.in_valid = 1'b0;
    tick();
    exp_q.delete(0);
    bus.out_ready = 1'b0;
    check("bp_empty", 32'(bus.out_valid), 32'd0);
    check("bp_xfer", 32'(xfer_cnt), 32'd6);
    check("bp_no_dup", 32'(exp_q.size()), 32'd0);

    // Streaming 100 vectors with random modes
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("st_rst_xfer", 32'(xfer_cnt), 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) begin
        check("st_valid", 32'(bus.out_valid), 32'd1);
        check_vec("st_vec", exp_q[0]);
        exp_q.delete(0);
      end
      check("st_rdy", 32'(bus.in_ready), 32'd1);
      fill_rand();
      m = 2'($urandom_range(0, 2));
      bus.in_data  = stim;
      bus.in_mode  = reorder_mode_t'(m);
      bus.in_valid = 1'b1;
      exp_q.push_back(model_vec(m));
      tick();
    end
    bus.in_valid = 1'b0;
    check_vec("st_last", exp_q[0]);
    exp_q.delete(0);
    tick();
    bus.out_ready = 1'b0;
    check("st_empty", 32'(bus.out_valid), 32'd0);
    check("st_xfer", 32'(xfer_cnt), 32'd100);
    check("st_mode_err", 32'(mode_err), 32'd0);

    // Reserved mode behaves as bypass and sets the sticky flag
    fill_rand();
    send(2'd3, "rsvd");
    check("rsvd_err", 32'(mode_err), 32'd1);
    pop_check("rsvd");
    fill_rand();
    send(2'd1, "rsvd_next");
    pop_check("rsvd_next");
    check("rsvd_sticky", 32'(mode_err), 32'd1);

    // Reset while full
    fill_rand();
    send(2'd0, "rf_a");
    send(2'd1, "rf_b");
    check("rf_full", 32'(bus.in_ready), 32'd0);
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    check("rf_out_valid", 32'(bus.out_valid), 32'd0);
    check("rf_in_ready", 32'(bus.in_ready), 32'd1);
    check("rf_xfer", 32'(xfer_cnt), 32'd0);
    check("rf_mode_err", 32'(mode_err), 32'd0);
    tick();
    check("rf_still_empty", 32'(bus.out_valid), 32'd0);

    // Small instance: TRANSPOSE {0,1,2,3} -> {0,2,1,3}
    for (int k = 0; k < 4; k++) sm.in_data[k] = 8'(k);
    sm.in_mode  = MODE_TRANSPOSE;
    sm.in_valid = 1'b1;
    tick();
    sm.in_valid = 1'b0;
    check("sm_valid", 32'(sm.out_valid), 32'd1);
    check("sm_out0", 32'(sm.out_data[0]), 32'd0);
    check("sm_out1", 32'(sm.out_data[1]), 32'd2);
    check("sm_out2", 32'(sm.out_data[2]), 32'd1);
    check("sm_out3", 32'(sm.out_data[3]), 32'd3);
    sm.out_ready = 1'b1;
    tick();
    sm.out_ready = 1'b0;
    check("sm_xfer1", 32'(sm_xfer), 32'd1);
    check("sm_empty", 32'(sm.out_valid), 32'd0);
    check("sm_mode_err", 32'(sm_err), 32'd0);

    // Small instance: stream until the transfer counter wraps
    sm.in_mode   = MODE_BYPASS;
    sm.in_valid  = 1'b1;
    sm.out_ready = 1'b1;
    cyc = 0;
    while (sm_xfer != 16'hFFFF && cyc < 70000) begin
      tick();
      cyc++;
    end
    check("sm_xfer_max", 32'(sm_xfer), 32'h0000FFFF);
    check("sm_wrap_cycles", 32'(cyc), 32'd65535);
    check("sm_wrap_valid", 32'(sm.out_valid), 32'd1);
    sm.in_valid = 1'b0;
    tick();
    sm.out_ready = 1'b0;
    check("sm_xfer_wrap", 32'(sm_xfer), 32'd0);
    check("sm_wrap_empty", 32'(sm.out_valid), 32'd0);

    // Report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
